// File: rtl/nios_sys_led_sequencer.sv
// -----------------------------------------------------------------------------
// nios_sys_led_sequencer
//
// Avalon-MM slave that drives an 8-bit LED port. In IDLE the port shows the
// manual DATA register. In RUN it steps through up to four pattern registers.
// Each pattern is held for PERIOD+1 cycles. The sequence either loops or
// finishes and sets a sticky done flag.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word address (0 DATA, 1 CTRL, 2 PERIOD, 3 STATUS, 4-7 PAT0..3)
//   chipselect slave select
//   write_n    active-low write strobe (zero wait states)
//   writedata  write data
//   readdata   read data, combinational from address, unused bits read 0
//   out_port   LED drive
//   irq        level interrupt, raised while done is set and enabled
//
// Build option
//   LED_SEQ_IRQ_EN  defined: irq = done & CTRL.irq_en, and CTRL[2] is RW.
//                   undefined: irq is tied low, and CTRL[2] ignores writes
//                   and reads 0.
// -----------------------------------------------------------------------------
module nios_sys_led_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port,
  output logic        irq
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [7:0]  data_r;
  logic        run_r;
  logic        loop_r;
  logic [1:0]  last_idx_r;
  logic [23:0] period_r;
  logic [7:0]  pat_r [0:3];
  logic        done_r;
  logic [1:0]  cur_idx_r;
  logic [23:0] cnt_r;

  logic        irq_en_s;
  logic        wr_s;
  logic        ctrl_wr_s;
  logic        status_wr_s;
  logic        start_s;
  logic        at_last_s;
  logic        step_s;
  logic        finish_s;
  logic        busy_s;
  logic [31:0] readdata_s;
  logic        unused_s;

  assign wr_s        = chipselect & ~write_n;
  assign ctrl_wr_s   = wr_s & (address == 3'd1);
  assign status_wr_s = wr_s & (address == 3'd3);
  assign start_s     = ctrl_wr_s & writedata[0];
  assign busy_s      = (state_r == ST_RUN);
  // ">=" rather than "==" so that lowering last_idx below the current
  // index mid-run still terminates the pass at the next step.
  assign at_last_s   = (cur_idx_r >= last_idx_r);
  assign unused_s    = ^writedata[31:24];

`ifdef LED_SEQ_IRQ_EN
  logic irq_en_r;

  // Interrupt enable bit of CTRL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      irq_en_r <= writedata[2];
    end
  end

  assign irq_en_s = irq_en_r;
`else
  assign irq_en_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and step decode; a CTRL write in RUN overrides stepping
  always_comb begin
    state_nxt_s = state_r;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start_s) begin
          state_nxt_s = ST_RUN;
        end else if (ctrl_wr_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 24'd0) begin
          step_s = 1'b1;
          if (at_last_s && !loop_r) begin
            finish_s    = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Host-writable configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r     <= 8'h00;
      loop_r     <= 1'b0;
      last_idx_r <= 2'd0;
      period_r   <= 24'd0;
      for (int i = 0; i < 4; i++) begin
        pat_r[i] <= 8'h00;
      end
    end else if (wr_s) begin
      case (address)
        3'd0: data_r <= writedata[7:0];
        3'd1: begin
          loop_r     <= writedata[1];
          last_idx_r <= writedata[5:4];
        end
        3'd2: period_r <= writedata[23:0];
        3'd4, 3'd5, 3'd6, 3'd7: pat_r[address[1:0]] <= writedata[7:0];
        default: ;
      endcase
    end
  end

  // Run bit: follows CTRL writes and self-clears when a one-shot finishes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      run_r <= writedata[0];
    end else if (finish_s) begin
      run_r <= 1'b0;
    end
  end

  // Sticky done flag; a completion in the same cycle as a W1C wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s | (done_r & ~(status_wr_s & writedata[1]));
    end
  end

  // Pattern index and hold counter. Completion rewinds the index to 0, so
  // STATUS reads as just "done". An abort holds the index where it stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_idx_r <= 2'd0;
      cnt_r     <= 24'd0;
    end else if (start_s) begin
      cur_idx_r <= 2'd0;
      cnt_r     <= period_r;
    end else if (step_s) begin
      if (finish_s) begin
        cur_idx_r <= 2'd0;
      end else if (at_last_s) begin
        cur_idx_r <= 2'd0;
        cnt_r     <= period_r;
      end else begin
        cur_idx_r <= cur_idx_r + 2'd1;
        cnt_r     <= period_r;
      end
    end else if (busy_s && !ctrl_wr_s) begin
      cnt_r <= cnt_r - 24'd1;
    end
  end

  // Read mux
  always_comb begin
    readdata_s = 32'h0000_0000;
    case (address)
      3'd0: readdata_s = {24'h00_0000, data_r};
      3'd1: readdata_s = {26'h000_0000, last_idx_r, 1'b0, irq_en_s, loop_r, run_r};
      3'd2: readdata_s = {8'h00, period_r};
      3'd3: readdata_s = {26'h000_0000, cur_idx_r, 2'b00, done_r, busy_s};
      3'd4, 3'd5, 3'd6, 3'd7: readdata_s = {24'h00_0000, pat_r[address[1:0]]};
      default: readdata_s = 32'h0000_0000;
    endcase
  end

  assign readdata = readdata_s;
  assign out_port = busy_s ? pat_r[cur_idx_r] : data_r;

`ifdef LED_SEQ_IRQ_EN
  assign irq = done_r & irq_en_s;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_nios_sys_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nios_sys_led_sequencer
//
// Directed self-checking bench for nios_sys_led_sequencer. Inputs change on
// the falling edge. Outputs are sampled on the falling edge or shortly after it.
// The interrupt expectations follow LED_SEQ_IRQ_EN.
// -----------------------------------------------------------------------------
module tb_nios_sys_led_sequencer;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int tests_run;
  int tests_failed;

`ifdef LED_SEQ_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  nios_sys_led_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: drives one write, returns on the next falling edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0000_0000;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    logic [7:0] exp_pat;
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    address      = 3'd0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = 32'h0000_0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out", {24'h0, out_port}, 32'h0000_0000);
    check("rst_irq", {31'h0, irq}, 32'h0000_0000);
    rd_check("rst_ctrl", 3'd1, 32'h0000_0000);
    rd_check("rst_status", 3'd3, 32'h0000_0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Manual mode
    wr(3'd0, 32'h0000_00A5);
    check("man_out", {24'h0, out_port}, 32'h0000_00A5);
    rd_check("man_rd", 3'd0, 32'h0000_00A5);
    @(negedge clk);

    // Writes without chipselect, or with write_n high, are ignored
    address = 3'd0; writedata = 32'h0000_003C; chipselect = 1'b0; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    check("nowr_out", {24'h0, out_port}, 32'h0000_00A5);

    // One-shot sequence, four patterns each held four cycles
    wr(3'd4, 32'h0000_0001);
    wr(3'd5, 32'h0000_0002);
    wr(3'd6, 32'h0000_0004);
    wr(3'd7, 32'h0000_0008);
    wr(3'd2, 32'h0000_0003);
    rd_check("per_rd", 3'd2, 32'h0000_0003);
    rd_check("pat2_rd", 3'd6, 32'h0000_0004);
    @(negedge clk);
    wr(3'd1, 32'h0000_0031);
    for (int i = 0; i < 16; i++) begin
      exp_pat = 8'h01 << (i / 4);
      check($sformatf("os_out%0d", i), {24'h0, out_port}, {24'h0, exp_pat});
      if (i == 5) rd_check("os_status_mid", 3'd3, 32'h0000_0011);
      @(negedge clk);
    end
    check("os_out_done", {24'h0, out_port}, 32'h0000_00A5);
    rd_check("os_status_done", 3'd3, 32'h0000_0002);
    rd_check("os_ctrl_done", 3'd1, 32'h0000_0030);
    check("os_irq", {31'h0, irq}, 32'h0000_0000);
    @(negedge clk);
    wr(3'd3, 32'h0000_0002);
    rd_check("w1c_status", 3'd3, 32'h0000_0000);
    @(negedge clk);

    // Loop mode, two patterns alternating every cycle
    wr(3'd2, 32'h0000_0000);
    wr(3'd1, 32'h0000_0013);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("loop_out%0d", i), {24'h0, out_port}, (i % 2 == 1) ? 32'h0000_0002 : 32'h0000_0001);
      @(negedge clk);
    end
    rd_check("loop_status", 3'd3, 32'h0000_0001);
    @(negedge clk);

    // Restart while running, then abort mid-step
    wr(3'd2, 32'h0000_0001);
    wr(3'd1, 32'h0000_0031);
    repeat (3) @(negedge clk);
    check("rs_before", {24'h0, out_port}, 32'h0000_0002);
    wr(3'd1, 32'h0000_0031);
    check("rs_out", {24'h0, out_port}, 32'h0000_0001);
    rd_check("rs_status", 3'd3, 32'h0000_0001);
    @(negedge clk);
    check("rs_reload", {24'h0, out_port}, 32'h0000_0001);
    @(negedge clk);
    check("ab_before", {24'h0, out_port}, 32'h0000_0002);
    wr(3'd1, 32'h0000_0000);
    check("ab_out", {24'h0, out_port}, 32'h0000_00A5);
    rd_check("ab_status", 3'd3, 32'h0000_0010);
    @(negedge clk);

    // Completion and W1C in the same cycle: set wins
    wr(3'd2, 32'h0000_0000);
    wr(3'd1, 32'h0000_0001);
    wr(3'd3, 32'h0000_0002);
    rd_check("prio_status", 3'd3, 32'h0000_0002);
    @(negedge clk);
    wr(3'd3, 32'h0000_0002);
    rd_check("prio_clr", 3'd3, 32'h0000_0000);
    @(negedge clk);

    // Interrupt
    wr(3'd1, 32'h0000_0005);
    check("irq_start", {31'h0, irq}, 32'h0000_0000);
    @(negedge clk);
    check("irq_set", {31'h0, irq}, {31'h0, IRQ_BUILD});
    rd_check("irq_status", 3'd3, 32'h0000_0002);
    rd_check("irq_ctrl", 3'd1, {29'h0, IRQ_BUILD, 2'b00});
    @(negedge clk);
    wr(3'd3, 32'h0000_0002);
    check("irq_clr", {31'h0, irq}, 32'h0000_0000);

    // Reset mid-run
    wr(3'd2, 32'h0000_0003);
    wr(3'd1, 32'h0000_0031);
    repeat (5) @(negedge clk);
    check("mr_before", {24'h0, out_port}, 32'h0000_0002);
    reset_n = 1'b0;
    #1;
    check("mr_out", {24'h0, out_port}, 32'h0000_0000);
    check("mr_irq", {31'h0, irq}, 32'h0000_0000);
    rd_check("mr_status", 3'd3, 32'h0000_0000);
    rd_check("mr_period", 3'd2, 32'h0000_0000);
    rd_check("mr_pat0", 3'd4, 32'h0000_0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mr_after", {24'h0, out_port}, 32'h0000_0000);
    rd_check("mr_status_after", 3'd3, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nios_sys_led_sequencer.md
NIOS_SYS_LED_SEQUENCER -- requirements
Module: nios_sys_led_sequencer

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-low, reset_n.
REQ-002 SHALL have the following ports:
- clk  input  1  system clock
- reset_n  input  1  async active-low reset
- address  input  3  Avalon-MM word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data, combinational from address; unused bits 0
- out_port  output  8  LED drive
- irq  output  1  level interrupt, sequence done
REQ-003 SHALL have no parameters; pattern depth is fixed at 4 entries of 8 bits.

Function
REQ-004 SHALL accept a write when chipselect=1 and write_n=0, with zero wait states; register updates appear the next cycle.
REQ-005 SHALL implement the following register map:
- 0 DATA[7:0]: manual LED value, RW
- 1 CTRL: [0] run, [1] loop, [2] irq_en, [5:4] last_idx; RW
- 2 PERIOD[23:0]: RW
- 3 STATUS: [0] busy, [1] done, [5:4] cur_idx; done is write-1-to-clear, other bits RO
- 4-7 PAT0..PAT3[7:0]: RW
REQ-006 SHALL implement FSM states IDLE and RUN.
REQ-007 SHALL drive out_port=DATA in IDLE and out_port=PAT[cur_idx] in RUN.
REQ-008 SHALL take IDLE->RUN on the cycle after a CTRL write with run=1, setting cur_idx=0, tick counter=PERIOD and busy=1.
REQ-009 SHALL decrement the tick counter each cycle in RUN; at counter==0 it SHALL advance one step, so each pattern is shown for exactly PERIOD+1 cycles (PERIOD=0 means 1 cycle).
REQ-010 SHALL define a step as follows:
- cur_idx<last_idx: cur_idx+1, reload counter.
- cur_idx==last_idx with loop=1: cur_idx=0, reload counter.
- cur_idx==last_idx with loop=0: go to IDLE, clear run and busy, set done.
REQ-011 SHALL abort to IDLE on the next cycle when CTRL is written with run=0 during RUN, with busy=0, done unchanged and cur_idx held.
REQ-012 SHALL restart from index 0 with a reloaded counter when CTRL is written with run=1 during RUN.
REQ-013 SHALL take PERIOD, PAT and last_idx writes during RUN effect at the next counter reload or next index read; no glitch resync.
REQ-014 SHALL give set priority when done set and a W1C clear occur in the same cycle.
REQ-015 SHALL return readdata=0 for any unmapped field.

Reset
REQ-016 SHALL, on reset_n=0, clear asynchronously: DATA, CTRL, PERIOD, PAT0-3, done, cur_idx and the counter all to 0, with FSM=IDLE, out_port=0x00 and irq=0.
REQ-017 SHALL, on reset assertion mid-RUN, abort immediately to the reset state with no completion flag.

Configuration
REQ-018 SHALL use macro LED_SEQ_IRQ_EN to select the interrupt feature.
- Defined: irq = done & irq_en, and CTRL[2] is RW.
- Undefined: irq is tied 0, CTRL[2] is written-ignored and reads 0; all other behaviour is identical.

Verification
REQ-019 SHALL verify manual mode: write DATA=0xA5 -> out_port=0xA5 next cycle; read addr0 -> 0x000000A5.
REQ-020 SHALL verify a one-shot sequence:
- Setup: PAT0-3=01,02,04,08; PERIOD=3; CTRL=0x31.
- Response: each pattern held 4 cycles; after 16 cycles out_port=DATA, STATUS=0x02.
REQ-021 SHALL verify loop mode: last_idx=1, loop=1, PERIOD=0 -> out_port alternates PAT0/PAT1 every cycle; done is never set.
REQ-022 SHALL verify abort: CTRL=0x00 written mid-step -> IDLE next cycle, busy=0, done=0.
REQ-023 SHALL verify the interrupt (LED_SEQ_IRQ_EN defined): CTRL=0x05 with PERIOD=0 -> irq=1 after 1 cycle; write STATUS=0x2 -> irq=0 next cycle.
REQ-024 SHALL verify reset mid-RUN: assert reset_n at cycle 5 of a sequence -> out_port=0x00, STATUS=0 immediately.
